delay_line_arbiter: RTL

- Two-requester controller that shares one 4-stage, 16-bit enable-gated delay line (chain of memory_reg_16bit stages, common `en`) between source A and source B.
- Arbitrates and muxes input samples, drives the line's `en`, and tracks per-stage valid/source tags in a shadow pipeline.
- Presents delayed samples on a valid/ready output with backpressure, and drains the line on request.

---
 rtl/delay_line_arbiter_if.sv | 26 ++
 rtl/delay_line_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/delay_line_arbiter_if.sv
// Handshake bundle for delay_line_arbiter: two input sources (A, B) and the
// delayed-sample output channel. The slave modport is the arbiter's view.
interface delay_line_arbiter_if #(
    parameter int W = 16
);
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/delay_line_arbiter.sv
// delay_line_arbiter: shares one external enable-gated delay line (DEPTH
// stages of W bits, common enable) between two sources with round-robin
// arbitration. A shadow pipeline of valid/source tags tracks what each line
// stage holds; the last stage is presented on a valid/ready output.
// Optional feature: define DELAY_LINE_ARBITER_AUTODRAIN_EN to drain the line
// automatically after IDLE_LIMIT idle cycles with samples stranded inside.
module delay_line_arbiter #(
    parameter int W          = 16,
    parameter int DEPTH      = 4,
    parameter int IDLE_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_line_arbiter_if.slave  bus,
    input  logic                 flush,
    output logic [W-1:0]         dl_in,
    output logic                 dl_en,
    input  logic [W-1:0]         dl_out,
    output logic [3:0]           occupancy,
    output logic                 busy
);

    if (DEPTH < 1 || DEPTH > 8 || IDLE_LIMIT < 1) begin : g_param_check
        $error("delay_line_arbiter: DEPTH must be 1..8 and IDLE_LIMIT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] src;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] src_nxt;
    logic [3:0]       occ_nxt;
    logic             last;        // source of the most recent grant: 0 = A, 1 = B
    logic             step_ok;
    logic             can_grant;
    logic             grant_a;
    logic             grant_b;
    logic             grant;
    logic             auto_drain;

    function automatic logic [3:0] popcount(input logic [DEPTH-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

`ifdef DELAY_LINE_ARBITER_AUTODRAIN_EN
    localparam int CNT_W = $clog2(IDLE_LIMIT + 1);

    logic [CNT_W-1:0] idle_cnt;

    assign auto_drain = (state == ST_RUN) && (idle_cnt == CNT_W'(IDLE_LIMIT));

    // Count RUN cycles in which samples sit in the line and nothing new arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state != ST_RUN || grant) begin
            idle_cnt <= '0;
        end else if (occupancy != 4'd0 && idle_cnt != CNT_W'(IDLE_LIMIT)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign auto_drain = 1'b0;
`endif

    // Arbitration, line enable and output presentation.
    always_comb begin
        // The line may advance only if the last stage is empty or being consumed.
        step_ok   = !vld[DEPTH-1] || bus.out_ready;
        // rst gating keeps ready low while reset is held even if sources are valid.
        can_grant = rst && step_ok && !flush && !auto_drain && (state != ST_DRAIN);
        // On a tie the source that did not win last time gets the slot.
        grant_a   = can_grant && bus.a_valid && (!bus.b_valid || last);
        grant_b   = can_grant && bus.b_valid && (!bus.a_valid || !last);
        grant     = grant_a || grant_b;
        dl_en     = step_ok && (grant || (state == ST_DRAIN));
        dl_in     = grant_b ? bus.b_data : bus.a_data;

        bus.a_ready   = grant_a;
        bus.b_ready   = grant_b;
        bus.out_valid = vld[DEPTH-1];
        bus.out_data  = dl_out;
        bus.out_src   = src[DEPTH-1];
        busy          = (state != ST_IDLE);
    end

    // Shadow tags follow the line exactly: shift on dl_en, stage 0 from the grant.
    always_comb begin
        vld_nxt = vld;
        src_nxt = src;
        if (dl_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_nxt[i] = vld[i-1];
                src_nxt[i] = src[i-1];
            end
            vld_nxt[0] = grant;
            src_nxt[0] = grant_b;
        end
        occ_nxt = popcount(vld_nxt);
    end

    // Shadow pipeline, occupancy and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            src       <= '0;
            occupancy <= 4'd0;
            last      <= 1'b1;
        end else begin
            vld       <= vld_nxt;
            src       <= src_nxt;
            occupancy <= occ_nxt;
            if (grant) begin
                last <= grant_b;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: IDLE ignores flush; DRAIN runs until the line is empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush || auto_drain) begin
                    state_nxt = ST_DRAIN;
                end else if (!grant && occ_nxt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (occ_nxt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
